// File: rtl/bleuart_recv_byte.sv
// UART byte receiver with oversampled start/data/stop sampling.
// Produces a one-cycle valid or ferr pulse per received frame.
module bleuart_recv_byte #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       tick,
  output logic [7:0] out,
  output logic       valid,
  output logic       ferr,
  output logic       busy
);

  localparam int SCW = $clog2(OVS);
  localparam logic [SCW-1:0] SC_HALF = SCW'(OVS / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVS - 1);
  localparam logic [SCW-1:0] SC_ONE  = SCW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [2:0]     bi_q, bi_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     out_q, out_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           meta_q, rxs_q;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      rxs_q  <= meta_q;
    end
  end

  // Receiver state, counters, shift register and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q    <= '0;
      bi_q    <= '0;
      shift_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bi_q    <= bi_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; everything advances only on oversample ticks.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bi_d    = bi_q;
    shift_d = shift_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_d = START;
            sc_d    = '0;
          end
        end
        START: begin
          sc_d = sc_q + SC_ONE;
          if (sc_q == SC_HALF) begin
            sc_d = '0;
            bi_d = '0;
            if (!rxs_q) begin
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          sc_d = sc_q + SC_ONE;
          if (sc_q == SC_LAST) begin
            sc_d          = '0;
            shift_d[bi_q] = rxs_q;
            bi_d          = bi_q + 3'd1;
            if (bi_q == 3'd7) begin
              state_d = STOP;
            end
          end
        end
        STOP: begin
          sc_d = sc_q + SC_ONE;
          if (sc_q == SC_LAST) begin
            sc_d    = '0;
            state_d = IDLE;
            if (rxs_q) begin
              out_d   = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          sc_d    = '0;
        end
      endcase
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_bleuart_recv_byte.sv
// Bench for bleuart_recv_byte: frame-level scoreboard plus
// directed scenarios and randomized frames with random tick spacing.
module tb_bleuart_recv_byte;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tick;
  logic [7:0] out;
  logic       valid;
  logic       ferr;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bit tick_hold    = 1'b0;
  int tick_gap_max = 0;

  logic [7:0] model_out = 8'h00;
  bit         exp_ferr_q[$];
  logic [7:0] exp_data_q[$];

  always #5 clk = ~clk;

  bleuart_recv_byte #(.OVS(OVS)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .tick (tick),
    .out  (out),
    .valid(valid),
    .ferr (ferr),
    .busy (busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Oversample tick source with random spacing.
  initial begin
    int gap;
    gap  = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_hold) begin
        tick = 1'b0;
      end else if (gap > 0) begin
        tick = 1'b0;
        gap--;
      end else begin
        tick = 1'b1;
        gap  = $urandom_range(0, tick_gap_max);
      end
    end
  end

  // Scoreboard: every pulse must match the next expected frame event,
  // and out must hold its last reported value between pulses.
  always @(negedge clk) begin
    bit         e_f;
    logic [7:0] e_d;
    if (rst === 1'b0) begin
      if (valid || ferr) begin
        chk("pulse_exclusive", {31'd0, valid && ferr}, 32'd0);
        chk("pulse_expected", {31'd0, exp_ferr_q.size() != 0}, 32'd1);
        if (exp_ferr_q.size() != 0) begin
          e_f = exp_ferr_q.pop_front();
          e_d = exp_data_q.pop_front();
          chk("pulse_kind", {31'd0, ferr}, {31'd0, e_f});
          if (!e_f && valid) begin
            chk("valid_data", {24'd0, out}, {24'd0, e_d});
            model_out = e_d;
          end else begin
            chk("ferr_out_hold", {24'd0, out}, {24'd0, model_out});
          end
        end
      end else begin
        chk("out_stable", {24'd0, out}, {24'd0, model_out});
      end
    end
  end

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick === 1'b1) c++;
    end
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_ferr_q.push_back(!stop_ok);
    exp_data_q.push_back(b);
    rx = 1'b0;
    wait_ticks(OVS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_ticks(OVS);
    end
    rx = stop_ok;
    wait_ticks(OVS);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_ferr_q.size() != 0 || busy) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk({name, "_drain_pending"}, exp_ferr_q.size(), 0);
    chk({name, "_drain_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst = 1'b1;
    model_out = 8'h00;
    exp_ferr_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    int w;
    bit t;
    bit ok;
    int gap;
    logic [7:0] b;

    rst = 1'b1;
    rx  = 1'b1;
    tick_gap_max = 1;
    do_reset();

    @(negedge clk);
    chk("reset_out", {24'd0, out}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy) hi++;
    end
    chk("idle_stays_idle", hi, 0);

    // 0xA5 with a tick every clk: also pins the valid latency.
    tick_gap_max = 0;
    wait_ticks(4);
    n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!valid && n < 400) begin
          @(posedge clk);
          n++;
          #1;
        end
      end
    join
    checks++;
    if (!(n inside {[150:160]})) begin
      errors++;
      $display("FAIL valid_latency actual=%0d required=150..160", n);
    end
    drain("a5");
    chk("a5_out", {24'd0, out}, 32'hA5);

    // Short low glitch: START rejects it after half a bit.
    tick_gap_max = 2;
    rx = 1'b0;
    n  = 0;
    fork
      begin
        wait_ticks(4);
        rx = 1'b1;
      end
      begin
        w = 0;
        while (!busy && w < 500) begin
          @(posedge clk);
          #1;
          w++;
        end
        w = 0;
        while (busy && w < 500) begin
          @(posedge clk);
          t = tick;
          #1;
          if (t) n++;
          w++;
        end
      end
    join
    chk("glitch_busy_ticks", n, 8);
    wait_ticks(2 * OVS);
    drain("glitch");
    chk("glitch_out", {24'd0, out}, 32'hA5);

    // Bad stop bit: ferr only, out keeps 0xA5.
    send_frame(8'h3C, 1'b0);
    wait_ticks(2 * OVS);
    drain("ferr");
    chk("ferr_keeps_out", {24'd0, out}, 32'hA5);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("b2b");
    chk("b2b_out", {24'd0, out}, 32'hFF);

    // Reset in the middle of bit 4, then a clean frame.
    b  = 8'hC3;
    rx = 1'b0;
    wait_ticks(OVS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_ticks(OVS);
    end
    rx = b[4];
    wait_ticks(OVS / 2);
    do_reset();
    @(negedge clk);
    chk("midreset_out", {24'd0, out}, 32'h00);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    wait_ticks(3 * OVS);
    send_frame(8'h5A, 1'b1);
    drain("rst5a");
    chk("rst5a_out", {24'd0, out}, 32'h5A);

    // Ticks frozen for 100 clk mid-frame.
    tick_gap_max = 1;
    hi = 0;
    fork
      send_frame(8'h96, 1'b1);
      begin
        wait_ticks(5 * OVS + 3);
        tick_hold = 1'b1;
        repeat (100) begin
          @(negedge clk);
          if (busy && !valid && !ferr) hi++;
        end
        tick_hold = 1'b0;
      end
    join
    chk("freeze_held", hi, 100);
    drain("freeze");
    chk("freeze_out", {24'd0, out}, 32'h96);

    // Randomized frames, tick spacing and idle gaps.
    for (int k = 0; k < 40; k++) begin
      tick_gap_max = $urandom_range(0, 3);
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      gap = ok ? $urandom_range(0, 20) : 32 + $urandom_range(0, 10);
      if (gap > 0) wait_ticks(gap);
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bleuart_recv_byte.md
BLEUART_RECV_BYTE -- requirements
Module: bleuart_recv_byte

Interface
REQ-001 SHALL have parameter OVS, default 16, meaning tick pulses per bit period; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port rx, input, 1, asynchronous UART line; idles at 1.
REQ-005 SHALL have port tick, input, 1, oversample enable pulse, one clk wide, OVS pulses per bit.
REQ-006 SHALL have port out, output, 8, last correctly received byte.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse meaning out has just been updated.
REQ-008 SHALL have port ferr, output, 1, one-cycle pulse meaning a framing error occurred.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer before use; "rxs" below means the synchronizer output.
REQ-011 SHALL implement four states: IDLE, START, DATA, STOP.
REQ-012 SHALL change state, counters, and the shift register only on cycles where tick=1; on all other cycles they hold.
REQ-013 SHALL use a sample counter sc of width ceil(log2(OVS)) and a bit index bi of 3 bits.
REQ-014 IDLE: on tick with rxs=0, SHALL go to START with sc=0.
REQ-015 START: on each tick, SHALL do sc+1; when sc=OVS/2-1 it SHALL check rxs.
- rxs=0: go to DATA with sc=0, bi=0.
- rxs=1: glitch; return to IDLE with no valid and no ferr.
REQ-016 DATA: on each tick, SHALL do sc+1; when sc=OVS-1 it SHALL write rxs into shift[bi] (LSB first) and set sc=0.
- bi=7: go to STOP.
- otherwise: bi+1.
REQ-017 STOP: on each tick, SHALL do sc+1; when sc=OVS-1 it SHALL go to IDLE and check rxs.
- rxs=1: out=shift and valid=1 for that cycle.
- rxs=0: ferr=1 for that cycle, and out is unchanged.
REQ-018 SHALL keep valid and ferr registered, never both high, and each high for exactly one clk.
REQ-019 SHALL keep out stable between valid pulses.
REQ-020 SHALL sample each data bit mid-bit, since the START check occurs at the half-bit point.
REQ-021 SHALL be able to detect a new start bit on the first tick in IDLE after STOP completes (back-to-back frames, no extra idle required).
REQ-022 SHALL, when rxs stays 0 after a framing error, treat it as a new start edge in IDLE (break condition re-syncs, no lockup).
REQ-023 SHALL produce its valid pulse in the clk cycle following the STOP-sampling tick.
REQ-024 SHALL emit valid about 9.5 bit periods plus 2 clk of synchronizer delay after the rx falling edge.

Reset
REQ-025 On rst=1 at a clk edge, SHALL set state=IDLE, sc=0, bi=0, shift=0x00, out=0x00, valid=0, ferr=0, busy=0, and synchronizer flops=1.
REQ-026 SHALL let rst override tick and take effect mid-frame, discarding the partial byte with no valid and no ferr.
REQ-027 After reset release with rx=1, SHALL stay in IDLE indefinitely.

Verification
REQ-028 Bench SHALL cover: OVS=16, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one valid pulse, out=0xA5, ferr never high.
REQ-029 Bench SHALL cover: rx low for only 4 ticks then high -> return to IDLE, no valid, no ferr, busy drops after 8 ticks.
REQ-030 Bench SHALL cover: frame 0x3C with stop bit 0 -> one ferr pulse, no valid, out keeps its previous value.
REQ-031 Bench SHALL cover: back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, out=0x00 then 0xFF.
REQ-032 Bench SHALL cover: rst asserted during bit 4 of a frame, then a clean 0x5A frame -> no output from the first frame, valid with out=0x5A for the second.
REQ-033 Bench SHALL cover: tick held low for 100 clk in mid-frame -> state, sc, and bi frozen; the frame completes correctly once ticks resume.
